lbm_step_scheduler: RTL

LBM_STEP_SCHEDULER -- requirements
Module: lbm_step_scheduler

---
 rtl/lbm_step_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lbm_step_scheduler.sv
// rtl/lbm_step_scheduler.sv - run sequencer for the LBM solver: step kicks, ping-pong bank select and AXI-stream dumps
// A run is num_steps solver steps with a DMA dump every dump_interval steps and always after the last one.
module lbm_step_scheduler #(
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] num_steps,
    input  logic [15:0] dump_interval,
    input  logic        step_done,
    input  logic        dump_done,
    output logic        solver_en,
    output logic        step_start,
    output logic        bank_sel,
    output logic        dump_start,
    output logic [31:0] step_count,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_WAIT_STEP,
        S_DUMP,
        S_WAIT_DUMP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t      state_q;
    logic [31:0] num_steps_q;
    logic [15:0] dump_interval_q;
    logic [31:0] step_count_q;
    logic [15:0] since_dump_q;
    logic [19:0] wdog_q;
    logic        final_q;

    logic        solver_en_q;
    logic        step_start_q;
    logic        bank_sel_q;
    logic        dump_start_q;
    logic        busy_q;
    logic        done_q;
    logic        timeout_err_q;

    logic [31:0] step_count_d;
    logic [15:0] since_dump_d;
    logic [19:0] wdog_d;
    logic        wdog_expired;
    logic        last_step;
    logic        interval_hit;

    assign step_count_d = step_count_q + 32'd1;
    assign since_dump_d = since_dump_q + 16'd1;
    assign wdog_d       = wdog_q + 20'd1;
    assign wdog_expired = (wdog_q == TIMEOUT - 20'd1);
    assign last_step    = (step_count_d == num_steps_q);
    assign interval_hit = (dump_interval_q != 16'd0) && (since_dump_d == dump_interval_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            num_steps_q     <= 32'd0;
            dump_interval_q <= 16'd0;
            step_count_q    <= 32'd0;
            since_dump_q    <= 16'd0;
            wdog_q          <= 20'd0;
            final_q         <= 1'b0;
            solver_en_q     <= 1'b0;
            step_start_q    <= 1'b0;
            bank_sel_q      <= 1'b0;
            dump_start_q    <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            step_start_q <= 1'b0;
            dump_start_q <= 1'b0;
            // busy_q is high exactly in the four active states, so it doubles as the abort qualifier
            if (abort && busy_q) begin
                state_q     <= S_IDLE;
                solver_en_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE, S_FAULT: begin
                        if (start && (num_steps != 32'd0)) begin
                            num_steps_q     <= num_steps;
                            dump_interval_q <= dump_interval;
                            step_count_q    <= 32'd0;
                            since_dump_q    <= 16'd0;
                            final_q         <= 1'b0;
                            done_q          <= 1'b0;
                            timeout_err_q   <= 1'b0;
                            solver_en_q     <= 1'b1;
                            busy_q          <= 1'b1;
                            step_start_q    <= 1'b1;
                            state_q         <= S_STEP;
                        end else if (start) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (state_q == S_DONE) begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_STEP: begin
                        wdog_q  <= 20'd0;
                        state_q <= S_WAIT_STEP;
                    end
                    S_WAIT_STEP: begin
                        if (step_done) begin
                            step_count_q <= step_count_d;
                            bank_sel_q   <= ~bank_sel_q;
                            if (last_step) begin
                                final_q      <= 1'b1;
                                since_dump_q <= since_dump_d;
                                dump_start_q <= 1'b1;
                                state_q      <= S_DUMP;
                            end else if (interval_hit) begin
                                final_q      <= 1'b0;
                                since_dump_q <= 16'd0;
                                dump_start_q <= 1'b1;
                                state_q      <= S_DUMP;
                            end else begin
                                since_dump_q <= since_dump_d;
                                step_start_q <= 1'b1;
                                state_q      <= S_STEP;
                            end
                        end else if (wdog_expired) begin
                            timeout_err_q <= 1'b1;
                            solver_en_q   <= 1'b0;
                            busy_q        <= 1'b0;
                            state_q       <= S_FAULT;
                        end else begin
                            wdog_q <= wdog_d;
                        end
                    end
                    S_DUMP: begin
                        wdog_q  <= 20'd0;
                        state_q <= S_WAIT_DUMP;
                    end
                    S_WAIT_DUMP: begin
                        if (dump_done) begin
                            if (final_q) begin
                                done_q      <= 1'b1;
                                solver_en_q <= 1'b0;
                                busy_q      <= 1'b0;
                                state_q     <= S_DONE;
                            end else begin
                                step_start_q <= 1'b1;
                                state_q      <= S_STEP;
                            end
                        end else if (wdog_expired) begin
                            timeout_err_q <= 1'b1;
                            solver_en_q   <= 1'b0;
                            busy_q        <= 1'b0;
                            state_q       <= S_FAULT;
                        end else begin
                            wdog_q <= wdog_d;
                        end
                    end
                    default: begin
                        solver_en_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign solver_en   = solver_en_q;
    assign step_start  = step_start_q;
    assign bank_sel    = bank_sel_q;
    assign dump_start  = dump_start_q;
    assign step_count  = step_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule
